// File: rtl/conv_window_buf.sv
// K_H x K_W sliding-window register between the line-buffer column reader and the MAC array.
// Takes one column per handshake, shifts in either scan direction and emits a window every STRIDE columns.
module conv_window_buf #(
    parameter int DW     = 8,
    parameter int K_H    = 3,
    parameter int K_W    = 3,
    parameter int STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sol,
    input  logic                  in_dir,
    input  logic [K_H*DW-1:0]     in_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sol,
    output logic [K_H*K_W*DW-1:0] out_win
);

    localparam int CW = $clog2(K_W + 1);
    localparam int WW = K_H * K_W * DW;
    localparam logic [CW-1:0] NCOL_FULL  = CW'(K_W);
    localparam logic [CW-1:0] PHASE_LAST = CW'(STRIDE - 1);

    logic [WW-1:0] win_q, win_d, win_shift;
    logic [CW-1:0] ncol_q, ncol_d, ncol_acc;
    logic [CW-1:0] phase_q, phase_d, phase_acc;
    logic          dir_q, dir_d, eff_dir;
    logic          out_valid_q, out_valid_d;
    logic          out_sol_q, out_sol_d;
    logic          accept, drain, first_full;

    // The window register is the output, so it may only move once the held window is gone.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;
    assign eff_dir  = in_sol ? in_dir : dir_q;

    // Shift toward the far side of the scan so c=0 stays spatially leftmost either way.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        win_shift = win_q;
        for (int r = 0; r < K_H; r++) begin
            if (!eff_dir) begin
                for (int c = 0; c < K_W - 1; c++)
                    win_shift[(r*K_W + c)*DW +: DW] = win_q[(r*K_W + c + 1)*DW +: DW];
                win_shift[(r*K_W + K_W - 1)*DW +: DW] = in_col[r*DW +: DW];
            end else begin
                for (int c = 1; c < K_W; c++)
                    win_shift[(r*K_W + c)*DW +: DW] = win_q[(r*K_W + c - 1)*DW +: DW];
                win_shift[(r*K_W)*DW +: DW] = in_col[r*DW +: DW];
            end
        end
    end

    // Column count and stride phase as they would be after an accept this cycle.
    always_comb begin
        ncol_acc   = '0;
        phase_acc  = '0;
        first_full = 1'b0;
        if (in_sol)
            ncol_acc = CW'(1);
        else if (ncol_q == NCOL_FULL)
            ncol_acc = NCOL_FULL;
        else
            ncol_acc = ncol_q + CW'(1);

        first_full = (ncol_acc == NCOL_FULL) && (in_sol || (ncol_q != NCOL_FULL));

        if ((ncol_q == NCOL_FULL) && !in_sol)
            phase_acc = (phase_q == PHASE_LAST) ? '0 : phase_q + CW'(1);
    end

    always_comb begin
        win_d       = win_q;
        ncol_d      = ncol_q;
        phase_d     = phase_q;
        dir_d       = dir_q;
        out_valid_d = out_valid_q;
        out_sol_d   = out_sol_q;
        if (clr) begin
            // A beat arriving with clr is dropped; pixel data is left alone and masked by ncol.
            ncol_d      = '0;
            phase_d     = '0;
            out_valid_d = 1'b0;
            out_sol_d   = 1'b0;
        end else if (accept) begin
            win_d       = win_shift;
            ncol_d      = ncol_acc;
            phase_d     = phase_acc;
            dir_d       = eff_dir;
            out_valid_d = (ncol_acc == NCOL_FULL) && (phase_acc == '0);
            out_sol_d   = first_full;
        end else if (drain) begin
            out_valid_d = 1'b0;
            out_sol_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the window is a plain flop bank, not a RAM, so clearing it on reset is cheap and required.
            win_q       <= '0;
            ncol_q      <= '0;
            phase_q     <= '0;
            dir_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sol_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all state moves together on the edge.
            win_q       <= win_d;
            ncol_q      <= ncol_d;
            phase_q     <= phase_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            out_sol_q   <= out_sol_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sol   = out_sol_q;
    assign out_win   = win_q;

endmodule

// File: tb/tb_conv_window_buf.sv
// Directed bench for conv_window_buf: table of single-beat vectors plus hand sequences
// for stride, backpressure, asynchronous reset and clear.
module tb_conv_window_buf;

    localparam int DW  = 8;
    localparam int K_H = 3;
    localparam int K_W = 3;
    localparam int WW  = K_H * K_W * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_sol;
    logic          in_dir;
    logic [K_H*DW-1:0] in_col;
    logic          out_ready;

    logic          in_ready_s1, out_valid_s1, out_sol_s1;
    logic [WW-1:0] out_win_s1;
    logic          in_ready_s2, out_valid_s2, out_sol_s2;
    logic [WW-1:0] out_win_s2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_window_buf #(.DW(DW), .K_H(K_H), .K_W(K_W), .STRIDE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_s1), .in_sol(in_sol), .in_dir(in_dir),
        .in_col(in_col), .out_valid(out_valid_s1), .out_ready(out_ready),
        .out_sol(out_sol_s1), .out_win(out_win_s1)
    );

    conv_window_buf #(.DW(DW), .K_H(K_H), .K_W(K_W), .STRIDE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_s2), .in_sol(in_sol), .in_dir(in_dir),
        .in_col(in_col), .out_valid(out_valid_s2), .out_ready(out_ready),
        .out_sol(out_sol_s2), .out_win(out_win_s2)
    );

    typedef struct {
        logic       valid;
        logic       sol;
        logic       dir;
        logic [7:0] pix;
        logic       exp_valid;
        logic       exp_sol;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [K_H*DW-1:0] col(input logic [7:0] v);
        return {v, v, v};
    endfunction

    function automatic logic [WW-1:0] mk_win(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K_H; r++) begin
            w[(r*K_W + 0)*DW +: DW] = p0;
            w[(r*K_W + 1)*DW +: DW] = p1;
            w[(r*K_W + 2)*DW +: DW] = p2;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sol, input logic dir, input logic [7:0] v);
        in_valid = 1'b1;
        in_sol   = sol;
        in_dir   = dir;
        in_col   = col(v);
        tick();
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] held;

        // valid sol dir pix | exp_valid exp_sol e0 e1 e2
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'd1,  1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd2,  1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd3,  1'b1, 1'b1, 8'd1,  8'd2,  8'd3 };
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd4,  1'b1, 1'b0, 8'd2,  8'd3,  8'd4 };
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd11, 1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd20, 1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd21, 1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'd22, 1'b1, 1'b1, 8'd20, 8'd21, 8'd22};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'd4,  1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'd3,  1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd2,  1'b1, 1'b1, 8'd2,  8'd3,  8'd4 };
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'd9,  1'b0, 1'b0, 8'd0,  8'd0,  8'd0 };
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'd1,  1'b1, 1'b0, 8'd1,  8'd2,  8'd3 };

        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_sol    = 1'b0;
        in_dir    = 1'b0;
        in_col    = '0;
        out_ready = 1'b1;
        #2;
        check("reset out_valid", WW'(out_valid_s1), WW'(1'b0));
        check("reset out_sol",   WW'(out_sol_s1),   WW'(1'b0));
        check("reset out_win",   out_win_s1,        '0);
        check("reset in_ready",  WW'(in_ready_s1),  WW'(1'b1));
        #10;
        rst_n = 1'b1;

        // Fill, drain-with-accept, line restart, reverse scan, idle and ignored in_sol.
        for (int i = 0; i < 15; i++) begin
            in_valid = vecs[i].valid;
            in_sol   = vecs[i].sol;
            in_dir   = vecs[i].dir;
            in_col   = col(vecs[i].pix);
            tick();
            check($sformatf("vec%0d out_valid", i), WW'(out_valid_s1), WW'(vecs[i].exp_valid));
            check($sformatf("vec%0d out_sol", i),   WW'(out_sol_s1),   WW'(vecs[i].exp_sol));
            check($sformatf("vec%0d in_ready", i),  WW'(in_ready_s1),  WW'(1'b1));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d out_win", i), out_win_s1, mk_win(vecs[i].e0, vecs[i].e1, vecs[i].e2));
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;

        // Stride 2: windows only after beats 3 and 5.
        for (int b = 1; b <= 6; b++) begin
            beat(b == 1, 1'b0, 8'(b));
            check($sformatf("stride beat%0d out_valid", b), WW'(out_valid_s2), WW'(b == 3 || b == 5));
            if (b == 3) begin
                check("stride beat3 out_win", out_win_s2, mk_win(8'd1, 8'd2, 8'd3));
                check("stride beat3 out_sol", WW'(out_sol_s2), WW'(1'b1));
            end
            if (b == 5) begin
                check("stride beat5 out_win", out_win_s2, mk_win(8'd3, 8'd4, 8'd5));
                check("stride beat5 out_sol", WW'(out_sol_s2), WW'(1'b0));
            end
        end

        // Backpressure: hold first window for 5 cycles while a beat is offered.
        beat(1'b1, 1'b0, 8'd1);
        beat(1'b0, 1'b0, 8'd2);
        out_ready = 1'b0;
        beat(1'b0, 1'b0, 8'd3);
        check("bp first out_valid", WW'(out_valid_s1), WW'(1'b1));
        check("bp first out_win", out_win_s1, mk_win(8'd1, 8'd2, 8'd3));
        held     = out_win_s1;
        in_valid = 1'b1;
        in_col   = col(8'd99);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp hold%0d in_ready", k),  WW'(in_ready_s1),  WW'(1'b0));
            check($sformatf("bp hold%0d out_valid", k), WW'(out_valid_s1), WW'(1'b1));
            check($sformatf("bp hold%0d out_sol", k),   WW'(out_sol_s1),   WW'(1'b1));
            check($sformatf("bp hold%0d out_win", k),   out_win_s1,        held);
        end
        out_ready = 1'b1;
        in_col    = col(8'd4);
        #1;
        check("bp release in_ready", WW'(in_ready_s1), WW'(1'b1));
        tick();
        in_valid = 1'b0;
        check("bp next out_valid", WW'(out_valid_s1), WW'(1'b1));
        check("bp next out_sol",   WW'(out_sol_s1),   WW'(1'b0));
        check("bp next out_win",   out_win_s1,        mk_win(8'd2, 8'd3, 8'd4));

        // Asynchronous reset while a window is held.
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", WW'(out_valid_s1), WW'(1'b0));
        check("async rst out_win",   out_win_s1,        '0);
        check("async rst in_ready",  WW'(in_ready_s1),  WW'(1'b1));
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // clr with an accepted beat: beat dropped, three more beats needed.
        beat(1'b1, 1'b0, 8'd1);
        beat(1'b0, 1'b0, 8'd2);
        clr = 1'b1;
        beat(1'b0, 1'b0, 8'd3);
        clr = 1'b0;
        check("clr out_valid", WW'(out_valid_s1), WW'(1'b0));
        beat(1'b0, 1'b0, 8'd4);
        check("clr beat1 out_valid", WW'(out_valid_s1), WW'(1'b0));
        beat(1'b0, 1'b0, 8'd5);
        check("clr beat2 out_valid", WW'(out_valid_s1), WW'(1'b0));
        beat(1'b0, 1'b0, 8'd6);
        check("clr beat3 out_valid", WW'(out_valid_s1), WW'(1'b1));
        check("clr beat3 out_sol",   WW'(out_sol_s1),   WW'(1'b1));
        check("clr beat3 out_win",   out_win_s1,        mk_win(8'd4, 8'd5, 8'd6));
        tick();
        check("clr drained out_valid", WW'(out_valid_s1), WW'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_window_buf.md
Name: conv_window_buf

Overview:
- Parametrised K_H x K_W sliding-window register for the conv datapath.
- Accepts one K_H-pixel column per handshake and emits a full window of K_H*K_W pixels once enough columns of the current line are loaded, honouring a configurable horizontal stride.
- Supports serpentine (bidirectional) scanning and output backpressure.
- Sits between the line-buffer column reader and the MAC array.

Parameters:
- DW, 8, pixel width in bits.
- K_H, 3, window height (rows per column beat).
- K_W, 3, window width (columns held).
- STRIDE, 1, horizontal stride in columns; legal range 1..K_W.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of the counters and out_valid; window data is kept.
- in_valid  input  1  column beat valid.
- in_ready  output  1  column beat accepted when in_valid && in_ready.
- in_sol  input  1  start-of-line; qualifies the accepted beat as the first column of a new line.
- in_dir  input  1  scan direction, sampled only on an accepted in_sol beat. 0 = left-to-right, 1 = right-to-left.
- in_col  input  K_H*DW  column pixels; row r at bits [r*DW +: DW].
- out_valid  output  1  window valid.
- out_ready  input  1  window consumed when out_valid && out_ready.
- out_sol  output  1  marks the first window of a line; valid with out_valid.
- out_win  output  K_H*K_W*DW  window; pixel (r,c) at bits [(r*K_W+c)*DW +: DW]; c=0 is spatially leftmost.

Behaviour:
- Reset (rst_n low, asynchronous): all window pixels 0, out_valid=0, out_sol=0, ncol=0, phase=0, dir=0. in_ready=1 after reset.
- Handshake rule: in_ready = !out_valid || out_ready, purely combinational. The window register is the output, so it never shifts while an unconsumed window is held.
- Accept with dir=0 (effective dir is in_dir if in_sol, else the latched dir):
  - Column c takes column c+1 for c=0..K_W-2.
  - Column K_W-1 takes in_col.
- Accept with dir=1:
  - Column c takes column c-1 for c=K_W-1..1.
  - Column 0 takes in_col.
  - The window therefore stays spatially ordered in both directions.
- Column count ncol (saturates at K_W):
  - Accept with in_sol sets ncol=1 and latches dir=in_dir. Any partial window from the previous line is discarded logically; stale pixels are masked by ncol.
  - Accept without in_sol sets ncol=min(ncol+1,K_W).
- Stride phase:
  - On the accept where the new ncol first reaches K_W, phase=0.
  - On each later accept with ncol already K_W, phase=(phase+1) mod STRIDE.
- Emit: on an accept, out_valid next cycle = (new ncol==K_W) && (new phase==0). Latency is 1 cycle from the accepted beat to the window on out_win/out_valid.
- out_sol next cycle = 1 when the emitted window is the first with ncol reaching K_W in this line; otherwise 0.
- No accept, out_valid && out_ready: out_valid and out_sol clear next cycle.
- Accept and drain in the same cycle: out_valid follows the emit rule; there is no bubble.
- out_valid && !out_ready: out_win, out_sol and out_valid are held stable and in_ready=0.
- clr: next cycle ncol=0, phase=0, out_valid=0, out_sol=0. clr has priority over a same-cycle accept, and that beat is dropped even though in_ready may have been 1.
- in_sol with in_valid low has no effect. in_sol is only meaningful on an accepted beat.
- Widths: counters are $clog2(K_W+1) bits. No arithmetic is performed on pixel data.

Test Plan:
- Basic fill, K_H=3, K_W=3, STRIDE=1, dir=0, out_ready=1: beats col j all rows = j+1 (1,2,3,4), first with in_sol -> out_valid 1 cycle after beat 3 with columns [1,2,3] and out_sol=1; after beat 4, [2,3,4] and out_sol=0; no window after beats 1-2.
- Stride, STRIDE=2, beats 1..6 in one line -> windows only after beats 3 and 5: [1,2,3] and [3,4,5]; none after 4 or 6.
- Reverse scan, in_sol with in_dir=1, beats 4,3,2 -> out_win columns c0=2, c1=3, c2=4.
- Backpressure, out_ready=0 when the first window appears -> in_ready=0 and out_win stable for 5 cycles. Then raise out_ready with in_valid high -> window handed over and next window [2,3,4] valid the following cycle, no bubble.
- Line restart: after 2 beats, accept a beat with in_sol -> no window until 2 further beats; first window has out_sol=1 and contains only new-line columns.
- Reset and clear: assert rst_n low mid-stream while out_valid=1 -> out_valid=0 and out_win=0 immediately. Separately, pulse clr together with an accepted beat -> beat dropped, ncol=0, and 3 further beats are needed before a window.
